// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: default word widths and the
// parameter-fetch state encoding.
package nn_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [2:0] {
      ADDR_IDX = 3'd0,
      READ_IDX = 3'd1,
      ADDR_IN  = 3'd2,
      READ_IN  = 3'd3,
      LOAD     = 3'd4,
      VALID    = 3'd5,
      DONE     = 3'd6
   } fetch_state_t;

endpackage

// File: rtl/param_fetch_stage.sv
// Parameter-fetch stage: walks a neuron's connection list and hands one
// (input, weight) pair at a time to the MAC stage over a ready/valid handshake.
module param_fetch_stage
   import nn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              readyNextParam,
   input  logic [ADDR_W-1:0] numInputs,
   input  logic [DATA_W-1:0] weightVal,
   input  logic [DATA_W-1:0] indexVal,
   input  logic [DATA_W-1:0] inputVal,
   output logic [ADDR_W-1:0] weightAddr,
   output logic [ADDR_W-1:0] indexAddr,
   output logic [ADDR_W-1:0] inputAddr,
   output logic [DATA_W-1:0] neuronInput,
   output logic [DATA_W-1:0] neuronWeight,
   output logic              paramsReady
);

   fetch_state_t      state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [ADDR_W-1:0] input_addr_reg, input_addr_next;
   logic [DATA_W-1:0] neuron_input_reg, neuron_input_next;
   logic [DATA_W-1:0] neuron_weight_reg, neuron_weight_next;
   logic [DATA_W-1:0] wreg_reg, wreg_next;
   logic              params_ready_reg, params_ready_next;
   logic [ADDR_W-1:0] index_as_addr;

   // The index word is used unmodified as an address; only width adaptation.
   generate
      if (DATA_W >= ADDR_W) begin : g_idx_trunc
         assign index_as_addr = indexVal[ADDR_W-1:0];
      end else begin : g_idx_zext
         assign index_as_addr = {{(ADDR_W-DATA_W){1'b0}}, indexVal};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg         <= ADDR_IDX;
         ptr_reg           <= '0;
         input_addr_reg    <= '0;
         neuron_input_reg  <= '0;
         neuron_weight_reg <= '0;
         wreg_reg          <= '0;
         params_ready_reg  <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ptr_reg           <= ptr_next;
         input_addr_reg    <= input_addr_next;
         neuron_input_reg  <= neuron_input_next;
         neuron_weight_reg <= neuron_weight_next;
         wreg_reg          <= wreg_next;
         params_ready_reg  <= params_ready_next;
      end
   end

   // Each memory access takes two states: one to settle the address, one
   // for the synchronous read, after which the data is captured.
   always_comb begin
      state_next         = state_reg;
      ptr_next           = ptr_reg;
      input_addr_next    = input_addr_reg;
      neuron_input_next  = neuron_input_reg;
      neuron_weight_next = neuron_weight_reg;
      wreg_next          = wreg_reg;
      params_ready_next  = params_ready_reg;

      case (state_reg)
         ADDR_IDX: begin
            if (ptr_reg == numInputs) begin
               state_next = DONE;
            end else begin
               state_next = READ_IDX;
            end
         end
         READ_IDX: begin
            state_next = ADDR_IN;
         end
         ADDR_IN: begin
            wreg_next       = weightVal;
            input_addr_next = index_as_addr;
            state_next      = READ_IN;
         end
         READ_IN: begin
            state_next = LOAD;
         end
         LOAD: begin
            neuron_input_next  = inputVal;
            neuron_weight_next = wreg_reg;
            params_ready_next  = 1'b1;
            ptr_next           = ptr_reg + ADDR_W'(1);
            state_next         = VALID;
         end
         VALID: begin
            if (readyNextParam) begin
               params_ready_next = 1'b0;
               state_next        = ADDR_IDX;
            end
         end
         DONE: begin
            params_ready_next = 1'b0;
         end
         default: begin
            state_next = ADDR_IDX;
         end
      endcase
   end

   assign weightAddr   = ptr_reg;
   assign indexAddr    = ptr_reg;
   assign inputAddr    = input_addr_reg;
   assign neuronInput  = neuron_input_reg;
   assign neuronWeight = neuron_weight_reg;
   assign paramsReady  = params_ready_reg;

endmodule

// File: tb/tb_param_fetch_stage.sv
// Self-checking bench for param_fetch_stage: synchronous-read memory models
// feed the DUT; delivered pairs are compared with a list built from the memories.
module tb_param_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        readyNextParam = 1'b1;
   logic [15:0] numInputs = '0;
   logic [15:0] weightVal, indexVal, inputVal;
   logic [15:0] weightAddr, indexAddr, inputAddr;
   logic [15:0] neuronInput, neuronWeight;
   logic        paramsReady;

   logic [15:0] wmem [256];
   logic [15:0] xmem [256];
   logic [15:0] imem [256];

   int errors = 0;
   int checks = 0;

   param_fetch_stage #(.DATA_W(16), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .readyNextParam(readyNextParam), .numInputs(numInputs),
      .weightVal(weightVal), .indexVal(indexVal), .inputVal(inputVal),
      .weightAddr(weightAddr), .indexAddr(indexAddr), .inputAddr(inputAddr),
      .neuronInput(neuronInput), .neuronWeight(neuronWeight), .paramsReady(paramsReady)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories
   always @(posedge clk) begin
      weightVal <= wmem[weightAddr[7:0]];
      indexVal  <= xmem[indexAddr[7:0]];
      inputVal  <= imem[inputAddr[7:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reset, release, then follow the whole connection list. stall holds
   // readyNextParam low for that many cycles on the first pair; rnd drives it randomly.
   task automatic run_fetch(input int n, input int stall, input bit rnd);
      logic [15:0] exp_in [$];
      logic [15:0] exp_w  [$];
      logic [15:0] exp_ia [$];
      logic [15:0] held_in, held_w;
      int k = 0;
      int stall_left = stall;
      int budget;
      bit seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         exp_w.push_back(wmem[i]);
         exp_ia.push_back(xmem[i]);
         exp_in.push_back(imem[xmem[i][7:0]]);
      end
      numInputs = 16'(n);
      rst = 1'b0;
      readyNextParam = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      budget = n * (rnd ? 24 : 6) + stall + 20;
      for (int e = 1; e <= budget; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (paramsReady === 1'b1) begin
            if (k >= n) begin
               check("extra_pair", k, n - 1);
            end else begin
               if (!seen) begin
                  seen = 1'b1;
                  if (!rnd) check("pair_edge", e, 5 + 6 * k + (k > 0 ? stall : 0));
                  check("neuron_input", neuronInput, exp_in[k]);
                  check("neuron_weight", neuronWeight, exp_w[k]);
                  check("input_addr", inputAddr, exp_ia[k]);
                  held_in = neuronInput;
                  held_w  = neuronWeight;
               end else begin
                  check("hold_input", neuronInput, held_in);
                  check("hold_weight", neuronWeight, held_w);
               end
               check("ptr_in_valid", weightAddr, k + 1);
            end
         end
         if (rnd) begin
            readyNextParam = 1'($urandom_range(0, 1));
         end else if (paramsReady === 1'b1 && k == 0 && stall_left > 0) begin
            readyNextParam = 1'b0;
            stall_left--;
         end else begin
            readyNextParam = 1'b1;
         end
         if (paramsReady === 1'b1 && readyNextParam) begin
            k++;
            seen = 1'b0;
         end
      end
      check("pair_count", k, n);
      check("done_weight_addr", weightAddr, n);
      check("done_index_addr", indexAddr, n);
      check("done_ready", paramsReady, 1'b0);
      $display("fetch n=%0d stall=%0d rnd=%0d pairs=%0d", n, stall, rnd, k);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         wmem[i] = 16'hAAAA;
         xmem[i] = 16'hBBBB;
         imem[i] = 16'hCCCC;
      end

      // Reset values
      rst = 1'b0;
      numInputs = 16'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_input", neuronInput, 16'h0);
      check("rst_weight", neuronWeight, 16'h0);
      check("rst_ready", paramsReady, 1'b0);
      check("rst_weight_addr", weightAddr, 16'h0);
      check("rst_index_addr", indexAddr, 16'h0);
      check("rst_input_addr", inputAddr, 16'h0);
      $display("reset check done");

      // Constant memories
      run_fetch(3, 0, 1'b0);

      // Addressed memories
      for (int i = 0; i < 256; i++) begin
         wmem[i] = 16'(100 + i);
         xmem[i] = 16'((2 - i) & 255);
         imem[i] = 16'(50 + i);
      end
      run_fetch(3, 0, 1'b0);

      // Backpressure on the first pair
      run_fetch(3, 4, 1'b0);

      // Empty connection list
      run_fetch(0, 0, 1'b0);

      // Reset mid-fetch: second pair is in READ_IN after edge 9
      numInputs = 16'd3;
      readyNextParam = 1'b1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (e == 5) check("mid_first_valid", paramsReady, 1'b1);
      end
      check("mid_ptr_before", weightAddr, 16'd1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_input", neuronInput, 16'h0);
      check("mid_rst_weight", neuronWeight, 16'h0);
      check("mid_rst_ptr", weightAddr, 16'h0);
      check("mid_rst_input_addr", inputAddr, 16'h0);
      check("mid_rst_ready", paramsReady, 1'b0);
      $display("mid-fetch reset check done");
      run_fetch(3, 0, 1'b0);

      // Random memories, random lengths, random handshake
      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 256; i++) begin
            wmem[i] = 16'($urandom);
            xmem[i] = 16'($urandom_range(0, 255));
            imem[i] = 16'($urandom);
         end
         run_fetch(int'($urandom_range(1, 8)), 0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_fetch_stage.md
Name: param_fetch_stage

Overview:
- Parameter-fetch stage of the neuron datapath.
- Walks a neuron's connection list: for each input slot i it reads the weight and the source index, then reads the input value selected by that index.
- Presents one (neuronInput, neuronWeight) pair at a time to the downstream MAC stage using a ready/valid handshake (paramsReady / readyNextParam).
- Sits between the weight/index/input memories and the neuron accumulate stage.

Parameters:
- DATA_W, 16, width of weight, index, input and output data words.
- ADDR_W, 16, width of all memory addresses and of numInputs.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- readyNextParam  in  1  downstream accepts the current pair when high at a rising edge while paramsReady is high.
- numInputs  in  ADDR_W  number of pairs to fetch; must be held stable from reset release until DONE.
- weightVal  in  DATA_W  weight memory read data for weightAddr.
- indexVal  in  DATA_W  index memory read data for indexAddr.
- inputVal  in  DATA_W  input memory read data for inputAddr.
- weightAddr  out  ADDR_W  weight memory address; equals ptr.
- indexAddr  out  ADDR_W  index memory address; equals ptr.
- inputAddr  out  ADDR_W  input memory address; registered copy of the last indexVal.
- neuronInput  out  DATA_W  fetched input value.
- neuronWeight  out  DATA_W  fetched weight value.
- paramsReady  out  1  a valid pair is on neuronInput/neuronWeight.

Behaviour:
- Memory contract: all three memories are synchronous read. Data for an address is sampled at the second rising edge after the DUT changes that address (one cycle address-stable, one cycle read).
- Reset (rst==0 at edge):
  - ptr=0, inputAddr=0, neuronInput=0, neuronWeight=0, wreg=0, paramsReady=0.
  - State=ADDR_IDX.
  - Reset mid-operation aborts the current fetch and restarts from ptr=0.
- weightAddr and indexAddr are combinational copies of ptr.
- State machine (one transition per edge):
  - ADDR_IDX: if ptr==numInputs -> DONE; else -> READ_IDX.
  - READ_IDX: -> ADDR_IN.
  - ADDR_IN: capture wreg<=weightVal and inputAddr<=indexVal; -> READ_IN.
  - READ_IN: -> LOAD.
  - LOAD: capture neuronInput<=inputVal and neuronWeight<=wreg; set paramsReady<=1; ptr<=ptr+1; -> VALID.
  - VALID: hold all outputs. If readyNextParam==1 -> paramsReady<=0, next ADDR_IDX; else stay in VALID.
  - DONE: terminal until reset. paramsReady=0, ptr==numInputs, outputs hold their last values.
- Timing: first pair valid 5 edges after reset release. Steady-state throughput is one pair per 6 cycles with readyNextParam tied high.
- neuronInput/neuronWeight change only in LOAD, never while paramsReady is high.
- readyNextParam is ignored outside VALID.
- numInputs==0: ADDR_IDX goes straight to DONE, paramsReady never asserts.
- ptr increment is ADDR_W wide. numInputs=65535 is legal; ptr never wraps because DONE is reached first.
- indexVal is used unmodified as inputAddr (truncated/zero-extended to ADDR_W if widths differ).

Decomposition:
- Shared package (nn_pkg): DATA_W/ADDR_W defaults and the state enum {ADDR_IDX, READ_IDX, ADDR_IN, READ_IN, LOAD, VALID, DONE}.
- No sub-module needed; a single module holding the FSM, ptr counter and capture registers.

Test Plan:
- Reset values: hold rst=0 for 2 edges -> all outputs 0, paramsReady=0, weightAddr=indexAddr=0.
- Constant memories: numInputs=3, weightVal=16'hAAAA, indexVal=16'hBBBB, inputVal=16'hCCCC, readyNextParam=1:
  - paramsReady pulses one cycle at edges 5, 11, 17 after reset release.
  - Outputs CCCC/AAAA, inputAddr=BBBB.
  - weightAddr steps 0,1,2,3, then DONE with no further pulses.
- Addressed memories: weight[i]=100+i, index[i]=2-i, input[j]=50+j, numInputs=3 -> pairs (input,weight) = (52,100), (51,101), (50,102) in order.
- Backpressure: readyNextParam=0 for 4 cycles after the first paramsReady -> outputs and paramsReady held stable, ptr frozen. On release the next pair follows 6 edges later.
- numInputs=0 -> paramsReady never asserts; state DONE after the first edge past reset.
- Reset mid-fetch: assert rst=0 while in READ_IN -> outputs cleared, fetch restarts at ptr=0, first pair reproduced.
